// File: rtl/pipe_reg_chain.sv
// Generic pipeline register chain: STAGES payload/valid registers with hazard
// bubble insertion, leading-stage branch flush, global stall and event counters.
module pipe_reg_chain #(
    parameter int WIDTH       = 32,
    parameter int STAGES      = 4,
    parameter int HAZ_STAGE   = 1,
    parameter int FLUSH_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    output logic              in_ready,
    input  logic              freeze,
    input  logic              flush,
    input  logic              stall_all,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_data,
    output logic [STAGES-1:0] stage_valid,
    output logic [15:0]       bubble_cnt,
    output logic [15:0]       flush_cnt
);

    if (STAGES < 2 || STAGES > 8) begin : g_bad_stages
        $fatal(1, "pipe_reg_chain: STAGES must be in 2..8");
    end
    if (HAZ_STAGE < 1 || HAZ_STAGE > STAGES - 1) begin : g_bad_haz
        $fatal(1, "pipe_reg_chain: HAZ_STAGE must be in 1..STAGES-1");
    end
    if (FLUSH_DEPTH < 0 || FLUSH_DEPTH > STAGES) begin : g_bad_flush
        $fatal(1, "pipe_reg_chain: FLUSH_DEPTH must be in 0..STAGES");
    end

    logic [STAGES-1:0] v_q;
    logic [WIDTH-1:0]  d_q [STAGES];
    logic [15:0]       bubble_cnt_reg;
    logic [15:0]       flush_cnt_reg;

    assign in_ready = !freeze && !stall_all;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        localparam bit IS_HAZ   = (gi == HAZ_STAGE);
        localparam bit IS_POST  = (gi > HAZ_STAGE);
        localparam bit IN_FLUSH = (gi < FLUSH_DEPTH);

        logic             v_reg;
        logic             v_next;
        logic [WIDTH-1:0] d_reg;
        logic [WIDTH-1:0] d_next;

        if (gi == 0) begin : g_head
            // Stage 0 is always upstream of the hazard stage, so it holds on freeze.
            always_comb begin
                v_next = v_reg;
                d_next = d_reg;
                if (!stall_all && !freeze) begin
                    v_next = in_valid;
                    d_next = in_valid ? in_data : '0;
                end
                if (flush && IN_FLUSH) begin
                    v_next = 1'b0;
                    d_next = '0;
                end
            end
        end else begin : g_body
            always_comb begin
                v_next = v_reg;
                d_next = d_reg;
                if (!stall_all) begin
                    if (!freeze || IS_POST) begin
                        v_next = v_q[gi-1];
                        d_next = d_q[gi-1];
                    end else if (IS_HAZ) begin
                        v_next = 1'b0;
                        d_next = '0;
                    end
                end
                if (flush && IN_FLUSH) begin
                    v_next = 1'b0;
                    d_next = '0;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                v_reg <= 1'b0;
                d_reg <= '0;
            end else begin
                v_reg <= v_next;
                d_reg <= d_next;
            end
        end

        assign v_q[gi] = v_reg;
        assign d_q[gi] = d_reg;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bubble_cnt_reg <= '0;
            flush_cnt_reg  <= '0;
        end else begin
            if (freeze && !stall_all && bubble_cnt_reg != 16'hFFFF) begin
                bubble_cnt_reg <= bubble_cnt_reg + 16'd1;
            end
            if (flush && flush_cnt_reg != 16'hFFFF) begin
                flush_cnt_reg <= flush_cnt_reg + 16'd1;
            end
        end
    end

    assign stage_valid = v_q;
    assign out_valid   = v_q[STAGES-1];
    assign out_data    = d_q[STAGES-1];
    assign bubble_cnt  = bubble_cnt_reg;
    assign flush_cnt   = flush_cnt_reg;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Scoreboard bench for pipe_reg_chain: directed stimulus pushes expected outputs,
// a negedge monitor pops and compares every newly presented valid output.
module tb_pipe_reg_chain;
    localparam int W = 32;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         freeze = 1'b0;
    logic         flush = 1'b0;
    logic         stall_all = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [S-1:0] stage_valid;
    logic [15:0]  bubble_cnt;
    logic [15:0]  flush_cnt;

    pipe_reg_chain #(.WIDTH(W), .STAGES(S), .HAZ_STAGE(1), .FLUSH_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .freeze(freeze), .flush(flush), .stall_all(stall_all),
        .out_valid(out_valid), .out_data(out_data), .stage_valid(stage_valid),
        .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_q[$];
    bit           mon_en = 1'b0;
    logic         stall_seen = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [W-1:0] d, input bit keep);
        in_valid = 1'b1;
        in_data  = d;
        if (keep) exp_q.push_back(d);
        tick();
    endtask

    // A held output during stall_all is not a new transaction.
    always @(posedge clk) stall_seen <= stall_all;

    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid && !stall_seen) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_unexpected actual=%0h required=none", out_data);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    $display("OUT data=%0h expected=%0h", out_data, e);
                    check("out_data", out_data, e);
                end
            end
            if (!out_valid) check("invalid_data_zero", out_data, 0);
        end
    end

    initial begin
        // Reset held for two edges with live input
        rst = 1'b0; in_valid = 1'b1; in_data = 32'hAAAA;
        tick();
        mon_en = 1'b1;
        check("rst_stage_valid", stage_valid, 0);
        check("rst_out_data", out_data, 0);
        tick();
        check("rst_stage_valid2", stage_valid, 0);
        check("rst_bubble_cnt", bubble_cnt, 0);
        check("rst_flush_cnt", flush_cnt, 0);
        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        tick();
        check("rel_stage_valid", stage_valid, 0);
        check("rel_counters", {bubble_cnt, flush_cnt}, 0);

        // Streaming 1..0x10
        for (int i = 1; i <= 16; i++) begin
            feed(i[W-1:0], 1'b1);
            if (i == 2) check("stream_fill", stage_valid, 4'b0011);
            if (i == 3) check("stream_lat_early", out_valid, 0);
            if (i == 4) begin
                check("stream_lat_valid", out_valid, 1);
                check("stream_first", out_data, 32'h1);
            end
        end
        check("stream_full", stage_valid, 4'b1111);
        check("stream_ready", in_ready, 1);

        // Freeze with s0..s3 = 10,0F,0E,0D; upstream holds 0x11
        in_valid = 1'b1; in_data = 32'h11; freeze = 1'b1;
        #1;
        check("freeze_in_ready", in_ready, 0);
        tick();
        freeze = 1'b0;
        check("freeze_stage_valid", stage_valid, 4'b1101);
        check("freeze_bubble_cnt", bubble_cnt, 1);
        check("freeze_out", out_data, 32'h0E);
        for (int i = 32'h11; i <= 32'h23; i++) feed(i[W-1:0], i != 32'h23);
        check("preflush_full", stage_valid, 4'b1111);

        // Flush with s0..s3 = 23,22,21,20
        in_valid = 1'b0; in_data = '0; flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_stage_valid", stage_valid, 4'b1100);
        check("flush_cnt1", flush_cnt, 1);
        check("flush_out", out_data, 32'h21);
        tick();
        check("flush_drain1", stage_valid, 4'b1000);
        tick();
        check("flush_drain2", stage_valid, 4'b0000);
        tick();
        check("flush_drain3", out_valid, 0);

        // stall_all + flush
        feed(32'h30, 1'b1); feed(32'h31, 1'b1); feed(32'h32, 1'b0); feed(32'h33, 1'b0);
        check("sf_full", stage_valid, 4'b1111);
        in_valid = 1'b0; in_data = '0; stall_all = 1'b1; flush = 1'b1;
        tick();
        stall_all = 1'b0; flush = 1'b0;
        check("sf_stage_valid", stage_valid, 4'b1100);
        check("sf_out_held", out_data, 32'h30);
        check("sf_bubble_cnt", bubble_cnt, 1);
        check("sf_flush_cnt", flush_cnt, 2);
        repeat (3) tick();
        check("sf_drained", stage_valid, 4'b0000);

        // stall_all + flush + freeze: freeze ignored
        feed(32'h40, 1'b1); feed(32'h41, 1'b1); feed(32'h42, 1'b0); feed(32'h43, 1'b0);
        in_valid = 1'b0; in_data = '0; stall_all = 1'b1; flush = 1'b1; freeze = 1'b1;
        #1;
        check("sff_in_ready", in_ready, 0);
        tick();
        stall_all = 1'b0; flush = 1'b0; freeze = 1'b0;
        check("sff_stage_valid", stage_valid, 4'b1100);
        check("sff_bubble_cnt", bubble_cnt, 1);
        check("sff_flush_cnt", flush_cnt, 3);
        repeat (3) tick();
        check("sff_drained", stage_valid, 4'b0000);

        // Saturation: bubble_cnt starts at 1
        in_valid = 1'b1; in_data = 32'h50; freeze = 1'b1;
        for (int n = 0; n < 65540; n++) begin
            tick();
            if (n == 65532) check("sat_fffe", bubble_cnt, 16'hFFFE);
            if (n == 65533) check("sat_ffff", bubble_cnt, 16'hFFFF);
        end
        freeze = 1'b0;
        check("sat_hold", bubble_cnt, 16'hFFFF);
        check("sat_empty", stage_valid, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            feed(32'h50 + i, 1'b1);
            if (i == 2) check("resume_lat_early", out_valid, 0);
            if (i == 3) begin
                check("resume_lat_valid", out_valid, 1);
                check("resume_first", out_data, 32'h50);
            end
        end
        in_valid = 1'b0; in_data = '0;
        repeat (4) tick();
        check("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
